// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, Hack screen window geometry and the
// scan-out FSM state type.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  localparam int X_OFFSET      = 64;
  localparam int Y_OFFSET      = 112;
  localparam int SCR_W         = 512;
  localparam int SCR_H         = 256;
  localparam int WORDS_PER_ROW = SCR_W / 16;

  typedef enum logic [1:0] {
    WAIT_LOAD  = 2'd0,
    WAIT_FRAME = 2'd1,
    RUN        = 2'd2
  } scan_state_t;

endpackage

// File: rtl/vga_timing.sv
// Free-running h/v raster counters with combinational sync and data-enable
// decode; callers register the decoded signals alongside their pixel data.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACT   = H_ACTIVE,
  parameter int H_FRONT = H_FP,
  parameter int H_PULSE = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FRONT = V_FP,
  parameter int V_PULSE = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       hs,
  output logic       vs,
  output logic       de,
  output logic       frame_end
);

  localparam logic [9:0] H_LAST = 10'(H_ACT + H_FRONT + H_PULSE + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACT + V_FRONT + V_PULSE + V_BACK - 1);
  localparam logic [9:0] HS_LO  = 10'(H_ACT + H_FRONT);
  localparam logic [9:0] HS_HI  = 10'(H_ACT + H_FRONT + H_PULSE - 1);
  localparam logic [9:0] VS_LO  = 10'(V_ACT + V_FRONT);
  localparam logic [9:0] VS_HI  = 10'(V_ACT + V_FRONT + V_PULSE - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACT);
  localparam logic [9:0] V_VIS  = 10'(V_ACT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  assign hs        = !((h >= HS_LO) && (h <= HS_HI));
  assign vs        = !((v >= VS_LO) && (v <= VS_HI));
  assign de        = (h < H_VIS) && (v < V_VIS);
  assign frame_end = (h == H_LAST) && (v == V_LAST);

endmodule

// File: rtl/vram_scanout.sv
// Hack screen scan-out: fetches one 16-bit VRAM word per 16 pixels of the
// centred 512x256 window and serialises it LSB-first onto a 1-bit video pin.
module vram_scanout
  import vga_pkg::*;
#(
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FRONT = V_FP,
  parameter int V_PULSE = V_SYNC,
  parameter int V_BACK  = V_BP,
  parameter int WIN_Y   = Y_OFFSET,
  parameter int WIN_H   = SCR_H
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vram_loaded,
  output logic        vram_rden,
  output logic [13:0] vram_raddr,
  input  logic [15:0] vram_data,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        video
);

  localparam logic [9:0] X_LO     = 10'(X_OFFSET);
  localparam logic [9:0] X_HI     = 10'(X_OFFSET + SCR_W - 1);
  localparam logic [9:0] FETCH_LO = 10'(X_OFFSET - 2);
  localparam logic [9:0] FETCH_HI = 10'(X_OFFSET + SCR_W - 18);
  localparam logic [9:0] ROW_LO   = 10'(WIN_Y);
  localparam logic [9:0] ROW_HI   = 10'(WIN_Y + WIN_H - 1);

  logic [9:0]  h;
  logic [9:0]  v;
  logic        hs_raw;
  logic        vs_raw;
  logic        de_raw;
  logic        frame_end;

  scan_state_t state;
  scan_state_t state_nxt;

  logic        active;
  logic        row_valid;
  logic [7:0]  row_idx;
  logic [8:0]  fetch_off;
  logic        fetch_hit;
  logic        rden_q;
  logic [15:0] shifter;
  logic        pix_raw;

  vga_timing #(
    .V_ACT   (V_ACT),
    .V_FRONT (V_FRONT),
    .V_PULSE (V_PULSE),
    .V_BACK  (V_BACK)
  ) u_timing (
    .clk       (clk),
    .reset_n   (reset_n),
    .h         (h),
    .v         (v),
    .hs        (hs_raw),
    .vs        (vs_raw),
    .de        (de_raw),
    .frame_end (frame_end)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= WAIT_LOAD;
    else          state <= state_nxt;
  end

  // Display only starts from a frame boundary so a half-drawn first frame never appears.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_LOAD:  if (vram_loaded) state_nxt = WAIT_FRAME;
      WAIT_FRAME: if (frame_end)   state_nxt = RUN;
      RUN:        state_nxt = RUN;
      default:    state_nxt = WAIT_LOAD;
    endcase
    if (!vram_loaded) state_nxt = WAIT_LOAD;
  end

  // Gating on vram_loaded directly stops reads and pixels in the very cycle it drops.
  assign row_valid = (v >= ROW_LO) && (v <= ROW_HI);
  assign row_idx   = 8'(v - ROW_LO);
  assign active    = (state == RUN) && vram_loaded && row_valid;

  // VRAM read port: a one-cycle rden with raddr; the word is on vram_data the
  // following cycle and is captured on the edge that ends that cycle.
  assign fetch_off  = 9'(h - FETCH_LO);
  assign fetch_hit  = (h >= FETCH_LO) && (h <= FETCH_HI) && (fetch_off[3:0] == 4'd0);
  assign vram_rden  = active && fetch_hit;
  assign vram_raddr = vram_rden ? 14'({row_idx, fetch_off[8:4]}) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rden_q  <= 1'b0;
      shifter <= '0;
    end else begin
      rden_q <= vram_rden;
      if (rden_q) shifter <= vram_data;
      else        shifter <= {1'b0, shifter[15:1]};
    end
  end

  assign pix_raw = active && (h >= X_LO) && (h <= X_HI) && shifter[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      de    <= 1'b0;
      video <= 1'b0;
    end else begin
      hsync <= hs_raw;
      vsync <= vs_raw;
      de    <= de_raw;
      video <= pix_raw;
    end
  end

endmodule

// File: tb/tb_vram_scanout.sv
// Bench for vram_scanout with a shortened vertical raster; pin values are
// predicted from an independent raster model and queued one cycle ahead.
module tb_vram_scanout;

  localparam int H_TOT   = 800;
  localparam int HS_LO   = 656;
  localparam int HS_HI   = 751;
  localparam int H_VIS   = 640;
  localparam int X0      = 64;
  localparam int X_LAST  = 575;
  localparam int FETCH0  = 62;
  localparam int FETCHN  = 558;
  localparam int V_VIS   = 12;
  localparam int V_FPB   = 2;
  localparam int V_SW    = 2;
  localparam int V_BPB   = 2;
  localparam int V_TOT   = V_VIS + V_FPB + V_SW + V_BPB;
  localparam int VS_LO   = 14;
  localparam int VS_HI   = 15;
  localparam int Y0      = 3;
  localparam int ROWS    = 4;
  localparam int NWORDS  = ROWS * 32;
  localparam int RUN_FRAME = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vram_loaded;
  logic        vram_rden;
  logic [13:0] vram_raddr;
  logic [15:0] vram_data;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        video;

  int checks = 0;
  int errors = 0;
  logic [3:0]  exp_q[$];
  logic [15:0] mem [0:NWORDS-1];

  int m_h, m_v, m_state, cur_frame;
  int hs_low, vs_low, rden_cnt, vid_ones, ones_exp, next_addr;
  int cyc, last_fall, rden_after_drop;
  bit have_fall, prev_hs, seen_first, drop_flag;

  vram_scanout #(
    .V_ACT   (V_VIS),
    .V_FRONT (V_FPB),
    .V_PULSE (V_SW),
    .V_BACK  (V_BPB),
    .WIN_Y   (Y0),
    .WIN_H   (ROWS)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .vram_loaded (vram_loaded),
    .vram_rden   (vram_rden),
    .vram_raddr  (vram_raddr),
    .vram_data   (vram_data),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .video       (video)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_pins(input string tag);
    check_eq({tag, "_hsync"}, 32'(hsync), 1);
    check_eq({tag, "_vsync"}, 32'(vsync), 1);
    check_eq({tag, "_de"},    32'(de), 0);
    check_eq({tag, "_video"}, 32'(video), 0);
    check_eq({tag, "_rden"},  32'(vram_rden), 0);
    check_eq({tag, "_raddr"}, 32'(vram_raddr), 0);
  endtask

  task automatic wait_pos(input int f, input int vv, input int hh);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 40000) begin
      @(posedge clk);
      #2;
      n++;
      hit = (cur_frame == f) && (m_v == vv) && (m_h == hh);
    end
    check_eq("reach_pos", 32'(hit), 1);
  endtask

  // VRAM model: word returned the cycle after rden, noise at all other times
  logic        rd_pend;
  logic [13:0] rd_addr;
  initial begin
    vram_data = 16'h0000;
    forever begin
      @(negedge clk);
      rd_pend = vram_rden;
      rd_addr = vram_raddr;
      @(posedge clk);
      #1;
      if (rd_pend) vram_data = (int'(rd_addr) < NWORDS) ? mem[rd_addr] : 16'hDEAD;
      else         vram_data = 16'($urandom_range(0, 65535));
    end
  end

  // scoreboard: expected pins pushed per counter value, popped one cycle later
  always @(negedge clk) begin : sb
    int row, idx;
    bit row_ok, e_rden, e_pix;
    int e_addr;
    logic [15:0] w;
    logic [3:0]  e_pins;
    if (!reset_n) begin
      m_h = 0; m_v = 0; m_state = 0; cur_frame = -1;
      exp_q.delete();
      exp_q.push_back(4'b1100);
      have_fall = 1'b0; prev_hs = 1'b1; cyc = 0;
      hs_low = 0; vs_low = 0; rden_cnt = 0; vid_ones = 0; next_addr = 0;
    end else begin
      cyc++;
      if (m_h == 0 && m_v == 0) begin
        if (cur_frame >= 0) begin
          check_eq("frame_hs_low", hs_low, 96 * V_TOT);
          check_eq("frame_vs_low", vs_low, V_SW * H_TOT);
          check_eq("frame_rden",   rden_cnt, (cur_frame == RUN_FRAME) ? NWORDS : 0);
          check_eq("frame_video1", vid_ones, (cur_frame == RUN_FRAME) ? ones_exp : 0);
        end
        cur_frame++;
        hs_low = 0; vs_low = 0; rden_cnt = 0; vid_ones = 0; next_addr = 0;
      end

      row_ok = (m_v >= Y0) && (m_v < Y0 + ROWS);
      row    = m_v - Y0;
      e_rden = (m_state == 2) && vram_loaded && row_ok &&
               (m_h >= FETCH0) && (m_h <= FETCHN) && ((m_h - FETCH0) % 16 == 0);
      e_addr = e_rden ? row * 32 + (m_h - FETCH0) / 16 : 0;
      e_pix  = 1'b0;
      if ((m_state == 2) && vram_loaded && row_ok && (m_h >= X0) && (m_h <= X_LAST)) begin
        idx   = m_h - X0;
        w     = mem[row * 32 + idx / 16];
        e_pix = w[idx % 16];
      end

      check_eq("rden",  32'(vram_rden), 32'(e_rden));
      check_eq("raddr", 32'(vram_raddr), e_addr);
      if (vram_rden) begin
        check_eq("addr_seq", 32'(vram_raddr), next_addr);
        next_addr++;
        rden_cnt++;
        if (drop_flag) rden_after_drop++;
        if (!seen_first) begin
          check_eq("first_v", m_v, Y0);
          check_eq("first_h", m_h, FETCH0);
          check_eq("first_addr", 32'(vram_raddr), 0);
          seen_first = 1'b1;
        end
      end

      check_eq("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e_pins = exp_q.pop_front();
        check_eq("pins", {28'd0, hsync, vsync, de, video}, {28'd0, e_pins});
      end
      exp_q.push_back({!((m_h >= HS_LO) && (m_h <= HS_HI)),
                       !((m_v >= VS_LO) && (m_v <= VS_HI)),
                       (m_h < H_VIS) && (m_v < V_VIS),
                       e_pix});
      check_eq("video_no_de", 32'(video & ~de), 0);

      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (video)  vid_ones++;
      if (prev_hs && !hsync) begin
        if (have_fall) check_eq("hs_period", cyc - last_fall, H_TOT);
        have_fall = 1'b1;
        last_fall = cyc;
      end
      prev_hs = hsync;

      if (!vram_loaded) m_state = 0;
      else if (m_state == 0) m_state = 1;
      else if (m_state == 1 && m_h == H_TOT - 1 && m_v == V_TOT - 1) m_state = 2;
      if (m_h == H_TOT - 1) begin
        m_h = 0;
        m_v = (m_v == V_TOT - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
  end

  initial begin
    for (int i = 0; i < NWORDS; i++) mem[i] = 16'(i) ^ 16'hA5A5;
    mem[0]          = 16'h0001;
    mem[31]         = 16'h8000;
    mem[NWORDS - 1] = 16'hFFFF;
    ones_exp = 0;
    for (int i = 0; i < NWORDS; i++) ones_exp += $countones(mem[i]);
    seen_first = 1'b0;
    drop_flag = 1'b0;
    rden_after_drop = 0;

    reset_n = 1'b0;
    vram_loaded = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_pins("rst");
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    wait_pos(2, 5, 123);
    vram_loaded = 1'b1;

    wait_pos(4, Y0 + 1, 300);
    vram_loaded = 1'b0;
    drop_flag = 1'b1;

    wait_pos(4, Y0 + 1, 400);
    check_eq("de_before_reset", 32'(de), 1);
    reset_n = 1'b0;
    #1;
    check_reset_pins("async_rst");

    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b1;
    vram_loaded = 1'b1;
    repeat (2000) @(posedge clk);
    #2;
    check_eq("first_seen", 32'(seen_first), 1);
    check_eq("rden_after_drop", rden_after_drop, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
